// File: rtl/imem_prog_loader.sv
// rtl/imem_prog_loader.sv - length-prefixed byte stream loader for the instruction memory
module imem_prog_loader #(
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE
    } state_t;

    localparam logic [16:0]    DEPTH_HDR = 17'(1) << ADDR_W;
    localparam logic [LEN_W:0] DEPTH_CNT = (LEN_W + 1)'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          word_hi_q, word_hi_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_wdata_q, mem_wdata_d;
    logic                core_hold_q, core_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [LEN_W-1:0]    words_loaded_q, words_loaded_d;

    logic                xfer;
    logic                writable;
    logic [15:0]         hdr_len;

    assign xfer     = in_valid && in_ready_q;
    assign hdr_len  = {len_q[15:8], in_data};
    // Words past the memory depth are still consumed, just never written.
    assign writable = {1'b0, words_loaded_q} < DEPTH_CNT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            word_hi_q      <= '0;
            in_ready_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            core_hold_q    <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            word_hi_q      <= word_hi_d;
            in_ready_q     <= in_ready_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            core_hold_q    <= core_hold_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_LEN_HI;
            S_LEN_HI:       if (xfer) state_d = S_LEN_LO;
            S_LEN_LO:       if (xfer) state_d = (hdr_len == 16'h0000) ? S_DONE : S_DATA_HI;
            S_DATA_HI:      if (xfer) state_d = S_DATA_LO;
            S_DATA_LO:      if (xfer) state_d = S_WRITE;
            S_WRITE:        state_d = (words_loaded_q + LEN_W'(1) == LEN_W'(len_q)) ? S_DONE : S_DATA_HI;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d          = len_q;
        word_hi_d      = word_hi_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        err_d          = err_q;
        words_loaded_d = words_loaded_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            words_loaded_d = '0;
            err_d          = 1'b0;
            mem_addr_d     = '0;
        end
        if (xfer) begin
            case (state_q)
                S_LEN_HI:  len_d[15:8] = in_data;
                S_LEN_LO: begin
                    len_d[7:0] = in_data;
                    err_d      = err_q | ({1'b0, hdr_len} > DEPTH_HDR);
                end
                S_DATA_HI: word_hi_d = in_data;
                S_DATA_LO: if (writable) begin
                    mem_wdata_d = {word_hi_q, in_data};
                    mem_addr_d  = words_loaded_q[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
        if (state_q == S_WRITE) words_loaded_d = words_loaded_q + LEN_W'(1);
        mem_we_d    = (state_d == S_WRITE) && writable;
        in_ready_d  = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO};
        core_hold_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_hold    = core_hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// tb/tb_imem_prog_loader.sv - self-checking bench for imem_prog_loader
module tb_imem_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    imem_prog_loader #(.ADDR_W(4), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [19:0] exp_q[$];
    logic [15:0] wq[$];
    int          wr_cyc[$];
    int          exp_wl = 0;
    logic        exp_err = 1'b0;
    logic        armed = 1'b0;
    logic        done_prev = 1'b0;
    int          done_cyc = -1;
    int          n_wr = 0;
    int          last_x = 0;
    logic        ready_watch = 1'b0;
    int          ready_viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: expected writes are word i at address i, for the first 16 words only.
    task automatic build_model(input int len);
        exp_q.delete();
        for (int i = 0; i < len; i++)
            if (i < 16) exp_q.push_back({i[3:0], wq[i]});
        exp_wl  = len;
        exp_err = (len > 16);
        armed   = 1'b1;
    endtask

    always @(negedge clk) begin
        logic [19:0] e;
        chk("hold_vs_done", {31'b0, core_hold}, {31'b0, ~done});
        if (mem_we) begin
            chk("we_ready_low", {31'b0, in_ready}, 32'd0);
            wr_cyc.push_back(cyc);
            n_wr++;
            chk("writes_pending", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", {28'b0, mem_addr}, {28'b0, e[19:16]});
                chk("wr_data", {16'b0, mem_wdata}, {16'b0, e[15:0]});
            end
        end
        if (done && !done_prev) done_cyc = cyc;
        if (done && armed) begin
            chk("done_wl", {16'b0, words_loaded}, exp_wl);
            chk("done_err", {31'b0, err}, {31'b0, exp_err});
            chk("done_pending", exp_q.size(), 32'd0);
        end
        if (ready_watch && !in_ready && !mem_we && !done) ready_viol++;
        done_prev = done;
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("byte_accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        last_x = cyc;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", {31'b0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_load(input int len, input int gap);
        do_start();
        build_model(len);
        wr_cyc.delete();
        n_wr = 0;
        done_cyc = -1;
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
        for (int i = 0; i < len; i++) begin
            send_byte(wq[i][15:8], gap);
            send_byte(wq[i][7:0], gap);
        end
        in_valid = 1'b0;
        wait_done();
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        armed = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_hold", {31'b0, core_hold}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_wl", {16'b0, words_loaded}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(posedge clk);
        apply_reset();
        chk("rst_addr", {28'b0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'b0, mem_wdata}, 32'd0);

        // Back-to-back stream: 00 03 12 34 AB CD 00 01
        wq = '{16'h1234, 16'hABCD, 16'h0001};
        run_load(3, 0);
        chk("t1_nwr", n_wr, 32'd3);
        chk("t1_gap01", wr_cyc[1] - wr_cyc[0], 32'd3);
        chk("t1_gap12", wr_cyc[2] - wr_cyc[1], 32'd3);
        chk("t1_we_lat", wr_cyc[2], last_x);
        chk("t1_done_lat", done_cyc, last_x + 1);
        chk("t1_wl", {16'b0, words_loaded}, 32'd3);
        chk("t1_err", {31'b0, err}, 32'd0);

        // Same stream with 5 idle cycles between bytes
        do_start();
        build_model(3);
        ready_watch = 1'b1;
        ready_viol  = 0;
        n_wr = 0;
        send_byte(8'h00, 5); send_byte(8'h03, 5);
        send_byte(8'h12, 5); send_byte(8'h34, 5);
        send_byte(8'hAB, 5); send_byte(8'hCD, 5);
        send_byte(8'h00, 5); send_byte(8'h01, 5);
        wait_done();
        ready_watch = 1'b0;
        chk("t2_nwr", n_wr, 32'd3);
        chk("t2_ready_viol", ready_viol, 32'd0);

        // Zero-length header
        wq.delete();
        run_load(0, 0);
        chk("t3_nwr", n_wr, 32'd0);
        chk("t3_done_lat", done_cyc, last_x);
        chk("t3_wl", {16'b0, words_loaded}, 32'd0);

        // Overlength: 18 words into a 16-word memory
        wq.delete();
        for (int i = 0; i < 18; i++) wq.push_back(16'hC000 + 16'(i * 17));
        do_start();
        build_model(18);
        n_wr = 0;
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        chk("t4_err_early", {31'b0, err}, 32'd1);
        for (int i = 0; i < 18; i++) begin
            send_byte(wq[i][15:8], 0);
            send_byte(wq[i][7:0], 0);
        end
        in_valid = 1'b0;
        wait_done();
        chk("t4_nwr", n_wr, 32'd16);
        chk("t4_wl", {16'b0, words_loaded}, 32'd18);
        chk("t4_err", {31'b0, err}, 32'd1);

        // Reset after DATA_HI of word 2, then a fresh load
        wq = '{16'h1234, 16'hABCD, 16'h0001};
        do_start();
        build_model(3);
        send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        chk("t5_wl_mid", {16'b0, words_loaded}, 32'd1);
        apply_reset();
        run_load(3, 0);
        chk("t5_nwr", n_wr, 32'd3);

        // Restart from DONE: 00 01 BE EF
        wq = '{16'hBEEF};
        do_start();
        chk("t6_hold", {31'b0, core_hold}, 32'd1);
        chk("t6_done_clr", {31'b0, done}, 32'd0);
        chk("t6_wl_clr", {16'b0, words_loaded}, 32'd0);
        build_model(1);
        n_wr = 0;
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        in_valid = 1'b0;
        wait_done();
        chk("t6_nwr", n_wr, 32'd1);
        chk("t6_wdata", {16'b0, mem_wdata}, 32'h0000BEEF);
        chk("t6_done", {31'b0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Byte-stream program loader that fills the 16-bit RISC core's instruction memory before execution.
- Receives a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 16-bit words.
- Issues single-cycle writes to the instruction memory write port.
- Holds the core in stall until the image is complete. It replaces the bench's hard-wired program image as the write side of the instruction memory.

Parameters:
- ADDR_W, 4, instruction memory address width; depth = 2^ADDR_W words.
- LEN_W, 16, width of the word-count header and the words_loaded counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- core_hold  out  1  stalls the core (PC/fetch frozen) while high.
- done  out  1  level; image loaded, core released.
- err  out  1  sticky; header length exceeded memory depth.
- words_loaded  out  LEN_W  count of words written so far.

Behaviour:
- Reset (rst_n=0 at a rising edge), all outputs registered:
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_hold=1, done=0, err=0, words_loaded=0.
- Byte transfer occurs on a rising edge with in_valid&&in_ready. in_data is sampled only then. in_valid may be held or dropped freely.
- States:
  - IDLE: in_ready=0. start -> LEN_HI; clears words_loaded, err, mem_addr.
  - LEN_HI: in_ready=1. Transfer stores len[15:8] -> LEN_LO.
  - LEN_LO: in_ready=1. Transfer stores len[7:0].
    - len==0 -> DONE.
    - Otherwise -> DATA_HI. err set if len>2^ADDR_W.
  - DATA_HI: in_ready=1. Transfer stores word[15:8] -> DATA_LO.
  - DATA_LO: in_ready=1. Transfer stores word[7:0] -> WRITE.
  - WRITE: in_ready=0 for exactly one cycle.
    - mem_we=1 with mem_wdata=word and mem_addr=words_loaded[ADDR_W-1:0], only if words_loaded<2^ADDR_W; otherwise mem_we=0 and the word is discarded.
    - words_loaded increments.
    - words_loaded+1==len -> DONE, else DATA_HI.
  - DONE: in_ready=0, core_hold=0, done=1. start -> LEN_HI; reasserts core_hold and clears done, err, words_loaded.
- Outputs per state:
  - core_hold=1 in every state except DONE.
  - done=1 only in DONE.
  - mem_we is high only in the WRITE cycle.
- Throughput: minimum 3 cycles per word (2 byte transfers + WRITE).
- Latency from the final data byte transfer:
  - mem_we asserts in the next cycle.
  - done=1 and core_hold=0 in the cycle after that.
- start outside IDLE/DONE is ignored. start with in_valid in the same cycle: the byte is not consumed (in_ready=0 in IDLE/DONE).
- Overlength (len>2^ADDR_W): all len words are consumed. Only the first 2^ADDR_W are written, mem_addr never wraps, err stays 1 until the next start or reset.
- words_loaded is LEN_W wide and saturates at neither end; len=0xFFFF is legal.
- Reset mid-load aborts immediately to IDLE with reset values. A partially written memory is not cleared.

Test Plan:
- Reset then start, stream 00 03 12 34 AB CD 00 01 with in_valid held high:
  - three mem_we pulses: addr0=0x1234, addr1=0xABCD, addr2=0x0001, each 3 cycles apart;
  - done=1 and core_hold=0 two cycles after the last byte; words_loaded=3; err=0.
- Same stream with in_valid deasserted for 5 cycles between every byte: identical writes, no byte lost or duplicated, in_ready=0 only in WRITE/IDLE/DONE.
- Header 00 00: DONE the cycle after LEN_LO transfer, no mem_we, words_loaded=0.
- ADDR_W=4, header 00 12 (18 words):
  - err=1 after LEN_LO;
  - 16 writes at addrs 0..15;
  - words 17–18 consumed with mem_we=0;
  - words_loaded=18, done=1.
- rst_n=0 after DATA_HI of word 2: next cycle IDLE, core_hold=1, in_ready=0, words_loaded=0. A fresh start and load then completes normally.
- After DONE, pulse start and send 00 01 BE EF: core_hold re-rises the cycle after start, single write addr0=0xBEEF, done again.
